// File: rtl/cae_layer_sched.sv
// Inference-pass sequencer for the CAE core: steps 3x3 conv windows over the feature map,
// then issues the FC line operations, with a completion watchdog and host start/done handshake.
module cae_layer_sched #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int FC_LINES = 4,
    parameter int CNT_W    = 8,
    parameter int TMO_CYC  = 1024
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             conv_comp,
    input  logic             fc_line_done,
    input  logic             fc_done,
    output logic             cae_enable,
    output logic             cae_layer,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             win_load,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WD_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 3);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 3);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(FC_LINES - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_C_LOAD,
        S_C_RUN,
        S_F_LOAD,
        S_F_RUN,
        S_F_FIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] row_reg, row_next;
    logic [CNT_W-1:0] col_reg, col_next;
    logic [WD_W-1:0]  wdog_reg, wdog_next;
    logic             err_reg, err_next;

    logic enable_reg, enable_next;
    logic layer_reg, layer_next;
    logic load_reg, load_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    logic wd_expired;
    assign wd_expired = (wdog_reg == WD_LAST);

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            wdog_reg   <= '0;
            err_reg    <= 1'b0;
            enable_reg <= 1'b0;
            layer_reg  <= 1'b0;
            load_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            wdog_reg   <= wdog_next;
            err_reg    <= err_next;
            enable_reg <= enable_next;
            layer_reg  <= layer_next;
            load_reg   <= load_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        wdog_next  = wdog_reg;
        err_next   = err_reg;

        if (abort) begin
            state_next = S_IDLE;
            row_next   = '0;
            col_next   = '0;
            wdog_next  = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_next = S_C_LOAD;
                        row_next   = '0;
                        col_next   = '0;
                        wdog_next  = '0;
                        err_next   = 1'b0;
                    end
                end
                S_C_LOAD: begin
                    state_next = S_C_RUN;
                    wdog_next  = '0;
                end
                S_C_RUN: begin
                    if (conv_comp) begin
                        wdog_next = '0;
                        if (col_reg == COL_LAST) begin
                            col_next = '0;
                            if (row_reg == ROW_LAST) begin
                                // Last window: the row counter becomes the FC line index.
                                row_next   = '0;
                                state_next = S_F_LOAD;
                            end else begin
                                row_next   = row_reg + 1'b1;
                                state_next = S_C_LOAD;
                            end
                        end else begin
                            col_next   = col_reg + 1'b1;
                            state_next = S_C_LOAD;
                        end
                    end else if (wd_expired) begin
                        state_next = S_ERR;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end
                S_F_LOAD: begin
                    state_next = S_F_RUN;
                    wdog_next  = '0;
                end
                S_F_RUN: begin
                    if (fc_line_done) begin
                        wdog_next = '0;
                        if (row_reg == LINE_LAST) begin
                            // fc_done may coincide with the final line; skip the wait in that case.
                            state_next = fc_done ? S_DONE : S_F_FIN;
                        end else begin
                            row_next   = row_reg + 1'b1;
                            state_next = S_F_LOAD;
                        end
                    end else if (wd_expired) begin
                        state_next = S_ERR;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end
                S_F_FIN: begin
                    if (fc_done) begin
                        wdog_next  = '0;
                        state_next = S_DONE;
                    end else if (wd_expired) begin
                        state_next = S_ERR;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            if (state_next == S_ERR && state_reg != S_ERR) begin
                err_next  = 1'b1;
                wdog_next = '0;
                row_next  = '0;
                col_next  = '0;
            end
            if (state_next == S_DONE) begin
                row_next = '0;
                col_next = '0;
            end
        end
    end

    // Flag outputs are decoded from the next state so they leave a register, glitch-free.
    always_comb begin
        enable_next = 1'b0;
        layer_next  = 1'b0;
        load_next   = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state_next)
            S_C_LOAD: begin
                load_next = 1'b1;
                busy_next = 1'b1;
            end
            S_C_RUN: begin
                enable_next = 1'b1;
                busy_next   = 1'b1;
            end
            S_F_LOAD: begin
                load_next  = 1'b1;
                layer_next = 1'b1;
                busy_next  = 1'b1;
            end
            S_F_RUN, S_F_FIN: begin
                enable_next = 1'b1;
                layer_next  = 1'b1;
                busy_next   = 1'b1;
            end
            S_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    assign cae_enable = enable_reg;
    assign cae_layer  = layer_reg;
    assign win_load   = load_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign win_row    = row_reg;
    assign win_col    = col_reg;

endmodule

// File: tb/tb_cae_layer_sched.sv
// Randomized bench for cae_layer_sched: a default-size instance driven through full passes,
// abort, async reset and timeout, plus a 3x3 / single-line instance with a short watchdog.
module tb_cae_layer_sched;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int FC_LINES = 4;
    localparam int CNT_W    = 8;
    localparam int TMO_CYC  = 1024;
    localparam int N_CONV   = (IMG_H - 2) * (IMG_W - 2);
    localparam int N_OPS    = N_CONV + FC_LINES;
    localparam int S_TMO    = 16;

    logic clk_i = 1'b0;
    logic rst   = 1'b0;

    logic start = 1'b0, abort = 1'b0, conv_comp = 1'b0, fc_line_done = 1'b0, fc_done = 1'b0;
    logic cae_enable, cae_layer, win_load, busy, done, err;
    logic [CNT_W-1:0] win_row, win_col;

    logic start_s = 1'b0, abort_s = 1'b0, conv_comp_s = 1'b0, fc_line_done_s = 1'b0, fc_done_s = 1'b0;
    logic cae_enable_s, cae_layer_s, win_load_s, busy_s, done_s, err_s;
    logic [CNT_W-1:0] win_row_s, win_col_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    cae_layer_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FC_LINES(FC_LINES), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)
    ) u_dut (
        .clk_i(clk_i), .rst(rst), .start(start), .abort(abort),
        .conv_comp(conv_comp), .fc_line_done(fc_line_done), .fc_done(fc_done),
        .cae_enable(cae_enable), .cae_layer(cae_layer), .win_row(win_row), .win_col(win_col),
        .win_load(win_load), .busy(busy), .done(done), .err(err)
    );

    cae_layer_sched #(
        .IMG_W(3), .IMG_H(3), .FC_LINES(1), .CNT_W(CNT_W), .TMO_CYC(S_TMO)
    ) u_small (
        .clk_i(clk_i), .rst(rst), .start(start_s), .abort(abort_s),
        .conv_comp(conv_comp_s), .fc_line_done(fc_line_done_s), .fc_done(fc_done_s),
        .cae_enable(cae_enable_s), .cae_layer(cae_layer_s), .win_row(win_row_s), .win_col(win_col_s),
        .win_load(win_load_s), .busy(busy_s), .done(done_s), .err(err_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pos_word(input logic layer, input logic [7:0] r, input logic [7:0] c);
        return {15'd0, layer, r, c};
    endfunction

    // One pass: expected load order comes from plain nested loops over windows and lines.
    task automatic do_pass(input int abort_at, input int rst_at, input string name);
        logic [31:0] exp_q[$];
        int lat;
        bit fc;
        bit coinc;
        for (int r = 0; r <= IMG_H - 3; r++)
            for (int c = 0; c <= IMG_W - 3; c++)
                exp_q.push_back(pos_word(1'b0, 8'(r), 8'(c)));
        for (int l = 0; l < FC_LINES; l++)
            exp_q.push_back(pos_word(1'b1, 8'(l), 8'd0));

        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        for (int op = 0; op < N_OPS; op++) begin
            fc = (op >= N_CONV);
            check("load_pulse", win_load, 1);
            check("load_pos", pos_word(cae_layer, win_row, win_col), exp_q[op]);
            check("load_busy", busy, 1);
            check("load_err", err, 0);
            check("load_en", cae_enable, 0);
            check("load_done", done, 0);
            @(negedge clk_i);
            check("load_once", win_load, 0);
            check("run_en", cae_enable, 1);

            lat = $urandom_range(0, 5);
            for (int k = 0; k < lat; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (fc) conv_comp = 1'b1;
                    else begin
                        fc_done      = 1'b1;
                        fc_line_done = 1'($urandom_range(0, 1));
                    end
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk_i);
                    conv_comp = 1'b0; fc_done = 1'b0; fc_line_done = 1'b0; start = 1'b0;
                    check("spur_en", cae_enable, 1);
                    check("spur_load", win_load, 0);
                    check("spur_pos", pos_word(cae_layer, win_row, win_col), exp_q[op]);
                end else begin
                    @(negedge clk_i);
                end
            end

            if (op == abort_at) begin
                abort = 1'b1;
                @(negedge clk_i);
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_en", cae_enable, 0);
                check("abort_pos", {win_row, win_col}, 0);
                repeat (5) begin
                    @(negedge clk_i);
                    check("abort_idle", {busy, cae_enable, win_load, done}, 0);
                end
                $display("[TB] %s: aborted at op %0d", name, op);
                return;
            end
            if (op == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_async", {cae_enable, cae_layer, win_load, busy, done, err, win_row, win_col}, 0);
                @(negedge clk_i);
                rst = 1'b1;
                repeat (6) begin
                    @(negedge clk_i);
                    check("rst_idle", {busy, cae_enable, win_load, done}, 0);
                end
                $display("[TB] %s: reset at op %0d", name, op);
                return;
            end

            if (!fc) begin
                conv_comp = 1'b1;
                @(negedge clk_i);
                conv_comp = 1'b0;
            end else if (op < N_OPS - 1) begin
                fc_line_done = 1'b1;
                @(negedge clk_i);
                fc_line_done = 1'b0;
            end else begin
                coinc        = 1'($urandom_range(0, 1));
                fc_line_done = 1'b1;
                fc_done      = coinc;
                @(negedge clk_i);
                fc_line_done = 1'b0;
                fc_done      = 1'b0;
                if (!coinc) begin
                    check("fin_en", cae_enable, 1);
                    check("fin_busy", busy, 1);
                    check("fin_done", done, 0);
                    lat = $urandom_range(0, 5);
                    repeat (lat) @(negedge clk_i);
                    check("fin_hold", cae_enable, 1);
                    fc_done = 1'b1;
                    @(negedge clk_i);
                    fc_done = 1'b0;
                end
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("done_layer", cae_layer, 0);
                check("done_en", cae_enable, 0);
                @(negedge clk_i);
                check("done_once", done, 0);
                check("idle_busy", busy, 0);
                check("idle_load", win_load, 0);
                $display("[TB] %s: %0d loads, done (coincident fc_done=%0d)", name, N_OPS, coinc);
            end
        end
    endtask

    task automatic do_timeout();
        int cyc;
        cyc   = 0;
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        check("tmo_load", pos_word(cae_layer, win_row, win_col), pos_word(1'b0, 8'd0, 8'd0));
        @(negedge clk_i);
        while (cae_enable && cyc < 3 * TMO_CYC) begin
            cyc++;
            @(negedge clk_i);
        end
        check("tmo_cycles", cyc, TMO_CYC);
        check("tmo_err", err, 1);
        check("tmo_en", cae_enable, 0);
        check("tmo_busy", busy, 0);
        repeat (3) @(negedge clk_i);
        check("tmo_sticky", err, 1);
        $display("[TB] timeout: err after %0d enable cycles", cyc);
    endtask

    task automatic small_tests();
        int cyc;
        start_s = 1'b1;
        @(negedge clk_i);
        start_s = 1'b0;
        check("s_load0", win_load_s, 1);
        check("s_pos0", pos_word(cae_layer_s, win_row_s, win_col_s), pos_word(1'b0, 8'd0, 8'd0));
        @(negedge clk_i);
        check("s_en0", cae_enable_s, 1);
        repeat ($urandom_range(0, 4)) @(negedge clk_i);
        conv_comp_s = 1'b1;
        @(negedge clk_i);
        conv_comp_s = 1'b0;
        check("s_fload", win_load_s, 1);
        check("s_fpos", pos_word(cae_layer_s, win_row_s, win_col_s), pos_word(1'b1, 8'd0, 8'd0));
        @(negedge clk_i);
        check("s_fen", cae_enable_s, 1);
        fc_line_done_s = 1'b1;
        fc_done_s      = 1'b1;
        @(negedge clk_i);
        fc_line_done_s = 1'b0;
        fc_done_s      = 1'b0;
        check("s_done", done_s, 1);
        check("s_done_busy", busy_s, 0);
        @(negedge clk_i);
        check("s_done_once", done_s, 0);
        $display("[TB] small: one window, one FC line, coincident fc_done");

        cyc     = 0;
        start_s = 1'b1;
        @(negedge clk_i);
        start_s = 1'b0;
        @(negedge clk_i);
        while (cae_enable_s && cyc < 100) begin
            cyc++;
            @(negedge clk_i);
        end
        check("s_tmo_cycles", cyc, S_TMO);
        check("s_tmo_err", err_s, 1);
        check("s_tmo_en", cae_enable_s, 0);
        start_s = 1'b1;
        @(negedge clk_i);
        start_s = 1'b0;
        check("s_restart_err", err_s, 0);
        check("s_restart_load", win_load_s, 1);
        check("s_restart_pos", pos_word(cae_layer_s, win_row_s, win_col_s), pos_word(1'b0, 8'd0, 8'd0));
        abort_s = 1'b1;
        @(negedge clk_i);
        abort_s = 1'b0;
        check("s_abort_busy", busy_s, 0);
        $display("[TB] small: timeout after %0d cycles, restart clears err", cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_out", {cae_enable, cae_layer, win_load, busy, done, err, win_row, win_col}, 0);
        check("rst_out_s", {cae_enable_s, cae_layer_s, win_load_s, busy_s, done_s, err_s, win_row_s, win_col_s}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_no_start", {busy, win_load, cae_enable}, 0);

        do_pass(-1, -1, "full");
        do_pass(-1, -1, "full2");
        do_pass(9, -1, "abort");
        do_pass(-1, -1, "after_abort");
        do_pass(-1, N_CONV + 1, "reset");
        do_pass(-1, -1, "after_reset");
        do_timeout();
        do_pass(-1, -1, "after_timeout");
        small_tests();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
